// File: rtl/shift_pipe.sv
// Pipelined SLL/SRL/SRA/ROL/ROR shifter with valid/ready flow control and tag passthrough.
// Define SHIFT_CARRY_EN to add the CARRY output (last bit shifted or rotated out).
module shift_pipe #(
  parameter  int WIDTH = 32,
  parameter  int PIPE  = 2,
  parameter  int TAGW  = 4,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] D,
  input  logic [SW-1:0]    SHAMT,
  input  logic [2:0]       OP,
  input  logic [TAGW-1:0]  IN_TAG,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RES,
  output logic [TAGW-1:0]  OUT_TAG
`ifdef SHIFT_CARRY_EN
  ,
  output logic             CARRY
`endif
);

  typedef struct packed {
    logic             valid;
    logic [2:0]       op;
    logic [SW-1:0]    amt;
    logic [TAGW-1:0]  tag;
`ifdef SHIFT_CARRY_EN
    logic             carry;
`endif
    logic [WIDTH-1:0] data;
  } stage_t;

  localparam int BASE = SW / PIPE;
  localparam int EXTRA = SW % PIPE;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [SW-1:0] AONE = SW'(1);

  // One mux level: shift or rotate by 2^k when amount bit k is set.
  function automatic stage_t level(input stage_t s, input int k);
    stage_t r;
    logic [SW-1:0] kbit;
    logic srl, sra, rol, ror;
    int sh;
`ifdef SHIFT_CARRY_EN
    int idx;
`endif
    r = s;
    kbit = AONE << k;
    sh = 1 << k;
    srl = (s.op == 3'b001);
    sra = (s.op == 3'b011);
    rol = (s.op == 3'b100);
    ror = (s.op == 3'b101);
    if (|(s.amt & kbit)) begin
      unique case (1'b1)
        srl: r.data = s.data >> sh;
        sra: r.data = $signed(s.data) >>> sh;
        rol: r.data = (s.data << sh) | (s.data >> (WIDTH - sh));
        ror: r.data = (s.data >> sh) | (s.data << (WIDTH - sh));
        default: r.data = s.data << sh;
      endcase
`ifdef SHIFT_CARRY_EN
      // the bit leaving at this level is the last one out so far
      idx = (srl || sra || ror) ? sh - 1 : WIDTH - sh;
      r.carry = |(s.data & (ONE << idx));
`endif
    end
    return r;
  endfunction

  stage_t in_s;
  stage_t src [PIPE];
  stage_t nxt [PIPE];
  stage_t q   [PIPE];
  logic   adv;
  logic   unused_tail;

  // Pack the accepted operation; carry starts at 0 so SHAMT=0 yields 0.
  always_comb begin
    in_s       = '0;
    in_s.valid = IN_VALID;
    in_s.op    = OP;
    in_s.amt   = SHAMT;
    in_s.tag   = IN_TAG;
    in_s.data  = D;
  end

  assign adv      = !OUT_VALID || OUT_READY;
  assign IN_READY = adv;

  for (genvar i = 0; i < PIPE; i++) begin : g_stg
    localparam int LO = i * BASE + ((i < EXTRA) ? i : EXTRA);
    localparam int HI = LO + BASE + ((i < EXTRA) ? 1 : 0);

    if (i == 0) begin : g_first
      assign src[i] = in_s;
    end else begin : g_rest
      assign src[i] = q[i-1];
    end

    // Apply this stage's mux levels in ascending order.
    always_comb begin
      stage_t t;
      t = src[i];
      for (int k = LO; k < HI; k++) begin
        t = level(t, k);
      end
      nxt[i] = t;
    end

    // Stage register; whole pipe moves together or freezes together.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        q[i] <= '0;
      end else if (adv) begin
        q[i] <= nxt[i];
      end
    end
  end

  assign OUT_VALID = q[PIPE-1].valid;
  assign RES       = q[PIPE-1].data;
  assign OUT_TAG   = q[PIPE-1].tag;
`ifdef SHIFT_CARRY_EN
  assign CARRY     = q[PIPE-1].carry;
`endif

  assign unused_tail = ^{q[PIPE-1].op, q[PIPE-1].amt};

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe (WIDTH=32, PIPE=2, TAGW=4).
// Carry checks are active when SHIFT_CARRY_EN is defined.
`timescale 1ns/1ps
module tb_shift_pipe;
  localparam int W  = 32;
  localparam int P  = 2;
  localparam int TW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          IN_VALID = 1'b0;
  logic          OUT_READY = 1'b1;
  logic          IN_READY;
  logic          OUT_VALID;
  logic [W-1:0]  D = '0;
  logic [W-1:0]  RES;
  logic [4:0]    SHAMT = '0;
  logic [2:0]    OP = '0;
  logic [TW-1:0] IN_TAG = '0;
  logic [TW-1:0] OUT_TAG;
`ifdef SHIFT_CARRY_EN
  logic          CARRY;
`endif

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    logic          c;
  } exp_t;

  typedef struct {
    logic [2:0]    op;
    logic [W-1:0]  d;
    logic [4:0]    sh;
    logic [TW-1:0] tag;
    logic [W-1:0]  res;
    logic          c;
  } vec_t;

  exp_t sb[$];

  shift_pipe #(.WIDTH(W), .PIPE(P), .TAGW(TW)) dut (
    .CLK(CLK),
    .RST(RST),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .D(D),
    .SHAMT(SHAMT),
    .OP(OP),
    .IN_TAG(IN_TAG),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .RES(RES),
    .OUT_TAG(OUT_TAG)
`ifdef SHIFT_CARRY_EN
    ,
    .CARRY(CARRY)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: whole-amount shift/rotate computed directly.
  function automatic logic [W-1:0] m_res(logic [2:0] op, logic [W-1:0] d, int n);
    logic [2*W-1:0] dd;
    logic [2*W-1:0] t;
    dd = {d, d};
    case (op)
      3'b001: return d >> n;
      3'b011: return $signed(d) >>> n;
      3'b100: begin t = dd << n; return t[2*W-1:W]; end
      3'b101: begin t = dd >> n; return t[W-1:0]; end
      default: return d << n;
    endcase
  endfunction

  function automatic logic m_carry(logic [2:0] op, logic [W-1:0] d, int n);
    logic [W-1:0] one;
    one = 1;
    if (n == 0) return 1'b0;
    if (op == 3'b001 || op == 3'b011 || op == 3'b101)
      return |(d & (one << (n - 1)));
    return |(d & (one << (W - n)));
  endfunction

  task automatic test_reset;
    RST = 1'b1;
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_chk++;
    if (OUT_VALID !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b want 0", OUT_VALID);
    end
    n_chk++;
    if (RES !== '0) begin
      n_fail++; $display("FAIL reset_res got %h want 0", RES);
    end
    n_chk++;
    if (OUT_TAG !== '0) begin
      n_fail++; $display("FAIL reset_tag got %h want 0", OUT_TAG);
    end
`ifdef SHIFT_CARRY_EN
    n_chk++;
    if (CARRY !== 1'b0) begin
      n_fail++; $display("FAIL reset_carry got %b want 0", CARRY);
    end
`endif
    RST = 1'b0;
    #1;
    n_chk++;
    if (IN_READY !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got %b want 1", IN_READY);
    end
    OUT_READY = 1'b1;
  endtask

  task automatic test_directed;
    vec_t v[$];
    logic [W-1:0] z;
    z = 32'h5A3C_96E1;
    v.push_back('{3'b011, 32'h8000_00F0, 5'd4,  4'd1, 32'hF800_000F, 1'b0});
    v.push_back('{3'b101, 32'h0000_0001, 5'd1,  4'd2, 32'h8000_0000, 1'b1});
    v.push_back('{3'b100, 32'h8000_0000, 5'd1,  4'd3, 32'h0000_0001, 1'b1});
    v.push_back('{3'b000, 32'hFFFF_FFFF, 5'd31, 4'd4, 32'h8000_0000, 1'b1});
    v.push_back('{3'b001, 32'hFFFF_FFFF, 5'd31, 4'd5, 32'h0000_0001, 1'b1});
    v.push_back('{3'b111, 32'h0000_00FF, 5'd8,  4'd6, 32'h0000_FF00, 1'b0});
    v.push_back('{3'b011, 32'h8000_0000, 5'd31, 4'd7, 32'hFFFF_FFFF, 1'b0});
    v.push_back('{3'b100, 32'h1234_5678, 5'd8,  4'd8, 32'h3456_7812, 1'b0});
    v.push_back('{3'b101, 32'h1234_5678, 5'd4,  4'd9, 32'h8123_4567, 1'b1});
    for (int o = 0; o < 8; o++)
      v.push_back('{3'(o), z, 5'd0, 4'(o + 10), z, 1'b0});
    foreach (v[j]) begin
      @(negedge CLK);
      OP = v[j].op; D = v[j].d; SHAMT = v[j].sh; IN_TAG = v[j].tag;
      IN_VALID = 1'b1; OUT_READY = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      IN_VALID = 1'b0;
      for (int c = 1; c < P; c++) begin
        n_chk++;
        if (OUT_VALID !== 1'b0) begin
          n_fail++; $display("FAIL dir_early_%0d got %b want 0", j, OUT_VALID);
        end
        @(posedge CLK);
        @(negedge CLK);
      end
      n_chk++;
      if (OUT_VALID !== 1'b1) begin
        n_fail++; $display("FAIL dir_valid_%0d got %b want 1", j, OUT_VALID);
      end
      n_chk++;
      if (RES !== v[j].res) begin
        n_fail++; $display("FAIL dir_res_%0d got %h want %h", j, RES, v[j].res);
      end
      n_chk++;
      if (OUT_TAG !== v[j].tag) begin
        n_fail++; $display("FAIL dir_tag_%0d got %h want %h", j, OUT_TAG, v[j].tag);
      end
`ifdef SHIFT_CARRY_EN
      n_chk++;
      if (CARRY !== v[j].c) begin
        n_fail++; $display("FAIL dir_carry_%0d got %b want %b", j, CARRY, v[j].c);
      end
`endif
    end
    @(posedge CLK);
  endtask

  task automatic test_mid_reset;
    @(negedge CLK);
    OP = 3'b000; D = 32'h1; SHAMT = 5'd4; IN_TAG = 4'd5;
    IN_VALID = 1'b1; OUT_READY = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    OP = 3'b101; D = 32'h3; SHAMT = 5'd1; IN_TAG = 4'd6;
    @(posedge CLK);
    @(negedge CLK);
    IN_VALID = 1'b0;
    RST = 1'b1;
    #1;
    n_chk++;
    if (OUT_VALID !== 1'b0) begin
      n_fail++; $display("FAIL mrst_valid got %b want 0", OUT_VALID);
    end
    n_chk++;
    if (RES !== '0) begin
      n_fail++; $display("FAIL mrst_res got %h want 0", RES);
    end
    n_chk++;
    if (OUT_TAG !== '0) begin
      n_fail++; $display("FAIL mrst_tag got %h want 0", OUT_TAG);
    end
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    n_chk++;
    if (IN_READY !== 1'b1) begin
      n_fail++; $display("FAIL mrst_ready got %b want 1", IN_READY);
    end
    OUT_READY = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      n_chk++;
      if (OUT_VALID !== 1'b0) begin
        n_fail++; $display("FAIL mrst_ghost_%0d got %b want 0", c, OUT_VALID);
      end
    end
  endtask

  task automatic test_back_to_back;
    int got[$];
    int nt;
    nt = 1;
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      OUT_READY = !(c >= 3 && c < 8);
      if (nt <= 3) begin
        IN_VALID = 1'b1; OP = 3'b000; D = 32'h3;
        SHAMT = 5'(nt); IN_TAG = 4'(nt);
      end else begin
        IN_VALID = 1'b0;
      end
      #1;
      if (c >= 3 && c < 8) begin
        n_chk++;
        if (IN_READY !== 1'b0) begin
          n_fail++; $display("FAIL b2b_ready_%0d got %b want 0", c, IN_READY);
        end
        n_chk++;
        if (OUT_VALID !== 1'b1 || OUT_TAG !== 4'd2) begin
          n_fail++;
          $display("FAIL b2b_hold_%0d got v=%b tag=%h want v=1 tag=2", c, OUT_VALID, OUT_TAG);
        end
        n_chk++;
        if (RES !== 32'hC) begin
          n_fail++; $display("FAIL b2b_res_%0d got %h want c", c, RES);
        end
      end
      if (OUT_VALID && OUT_READY) begin
        got.push_back(int'(OUT_TAG));
        n_chk++;
        if (RES !== m_res(3'b000, 32'h3, int'(OUT_TAG))) begin
          n_fail++;
          $display("FAIL b2b_out got %h want %h", RES, m_res(3'b000, 32'h3, int'(OUT_TAG)));
        end
      end
      if (IN_VALID && IN_READY) nt++;
      @(posedge CLK);
    end
    n_chk++;
    if (got.size() != 3) begin
      n_fail++; $display("FAIL b2b_count got %0d want 3", got.size());
    end
    foreach (got[i]) begin
      n_chk++;
      if (got[i] != i + 1) begin
        n_fail++; $display("FAIL b2b_order_%0d got %0d want %0d", i, got[i], i + 1);
      end
    end
  endtask

  task automatic test_random;
    bit hold, acc, fire, stalled;
    hold = 0; stalled = 0;
    sb.delete();
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge CLK);
      if (stalled) begin
        n_chk++;
        if (OUT_VALID !== 1'b1) begin
          n_fail++; $display("FAIL rnd_stall_%0d got %b want 1", cyc, OUT_VALID);
        end
      end
      if (OUT_VALID === 1'b1) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL rnd_spurious_%0d got tag %h want none", cyc, OUT_TAG);
        end else if (RES !== sb[0].res || OUT_TAG !== sb[0].tag) begin
          n_fail++;
          $display("FAIL rnd_out_%0d got %h/%h want %h/%h", cyc, RES, OUT_TAG, sb[0].res, sb[0].tag);
        end
`ifdef SHIFT_CARRY_EN
        if (sb.size() != 0) begin
          n_chk++;
          if (CARRY !== sb[0].c) begin
            n_fail++; $display("FAIL rnd_carry_%0d got %b want %b", cyc, CARRY, sb[0].c);
          end
        end
`endif
      end
      if (!hold) begin
        IN_VALID = ($urandom_range(0, 3) != 0);
        OP = 3'($urandom_range(0, 7));
        D = $urandom;
        SHAMT = 5'($urandom_range(0, 31));
        IN_TAG = TW'($urandom);
      end
      OUT_READY = ($urandom_range(0, 2) != 0);
      #1;
      n_chk++;
      if (IN_READY !== (!OUT_VALID || OUT_READY)) begin
        n_fail++;
        $display("FAIL rnd_ready_%0d got %b want %b", cyc, IN_READY, !OUT_VALID || OUT_READY);
      end
      acc = IN_VALID && IN_READY;
      fire = OUT_VALID && OUT_READY;
      stalled = OUT_VALID && !OUT_READY;
      @(posedge CLK);
      if (fire && sb.size() != 0) void'(sb.pop_front());
      if (acc) sb.push_back('{m_res(OP, D, int'(SHAMT)), IN_TAG, m_carry(OP, D, int'(SHAMT))});
      hold = IN_VALID && !acc;
    end
    for (int c = 0; c < 2 * P + 4; c++) begin
      @(negedge CLK);
      IN_VALID = 1'b0;
      OUT_READY = 1'b1;
      if (OUT_VALID === 1'b1) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL drain_spurious got tag %h want none", OUT_TAG);
        end else begin
          if (RES !== sb[0].res || OUT_TAG !== sb[0].tag) begin
            n_fail++;
            $display("FAIL drain_out got %h/%h want %h/%h", RES, OUT_TAG, sb[0].res, sb[0].tag);
          end
          @(posedge CLK);
          void'(sb.pop_front());
        end
      end
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL rnd_lost got %0d left want 0", sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_mid_reset;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
